// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RISC-V pipeline: forwarding, load-use stalls,
// branch flushes and memory-wait freeze with timeout. Optional perf counters: HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        sclr,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic [1:0]  ResultSrcE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        PCSrcE,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        StallW,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        mem_timeout,
  output logic        busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count,
  output logic [31:0] perf_fwd_count
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    TIMEOUT  = 2'b10
  } state_t;

  localparam logic [7:0] MaxWaitCnt = 8'(MAX_WAIT);

  state_t     state, stateNext;
  logic [7:0] waitCnt, waitCntNext;
  logic       memTimeoutNext;
  logic       frozen;
  logic       lwStall;
  logic [1:0] fwdA, fwdB;

  // Source-operand forwarding; the M stage holds the younger value so it wins over W.
  always_comb begin
    fwdA = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      fwdA = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) fwdA = 2'b01;
    fwdB = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      fwdB = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) fwdB = 2'b01;
  end

  assign lwStall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                   ((RdE == Rs1D) || (RdE == Rs2D));

  assign frozen = ((state == RUN) && MemReqM && !MemReadyM) ||
                  ((state == MEM_WAIT) && !MemReadyM) ||
                  (state == TIMEOUT);

  always_ff @(posedge clk) begin
    if (sclr) begin
      state       <= RUN;
      waitCnt     <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= stateNext;
      waitCnt     <= waitCntNext;
      mem_timeout <= memTimeoutNext;
    end
  end

  always_comb begin
    stateNext      = state;
    waitCntNext    = waitCnt;
    memTimeoutNext = mem_timeout;
    unique case (state)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          stateNext   = MEM_WAIT;
          waitCntNext = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          stateNext   = RUN;
          waitCntNext = '0;
        end else if (waitCnt == MaxWaitCnt) begin
          stateNext      = TIMEOUT;
          memTimeoutNext = 1'b1;
        end else begin
          waitCntNext = waitCnt + 8'd1;
        end
      end
      TIMEOUT: ;
      default: stateNext = RUN;
    endcase
  end

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    StallW    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    ForwardAE = fwdA;
    ForwardBE = fwdB;
    if (sclr) begin
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
    end else if (frozen) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      StallW = 1'b1;
    end else begin
      StallF = lwStall;
      StallD = lwStall;
      FlushD = PCSrcE;
      FlushE = lwStall | PCSrcE;
    end
  end

  assign busy = (state != RUN);

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (sclr) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
      perf_fwd_count    <= '0;
    end else begin
      if (StallF)                                      perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (PCSrcE && !frozen)                           perf_flush_count  <= perf_flush_count + 32'd1;
      if ((ForwardAE != 2'b00) || (ForwardBE != 2'b00)) perf_fwd_count   <= perf_fwd_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vectors with literal checks plus a per-cycle
// behavioural model. Define HAZARD_PERF_EN to also check the perf counters.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned MaxWait = 4;

  logic       clk;
  logic       sclr;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic       RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       mem_timeout, busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flush_count, perf_fwd_count;
`endif

  int checks;
  int failures;

  pipeline_hazard_ctrl #(.MAX_WAIT(MaxWait)) dut (
    .clk(clk), .sclr(sclr),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_timeout(mem_timeout), .busy(busy)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count),
    .perf_fwd_count(perf_fwd_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: consecutive frozen cycles of the current memory access, and the sticky timeout.
  int unsigned frozenCnt = 0;
  bit          timedOut  = 1'b0;
`ifdef HAZARD_PERF_EN
  logic [31:0] mStall = '0, mFlush = '0, mFwd = '0;
`endif

  function automatic logic [1:0] fwdRule(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      begin
        logic [1:0] eA, eB;
        logic [4:0] eStall;
        logic       eFD, eFE, load, frz;
        load = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        frz  = timedOut || ((frozenCnt == 0) ? (MemReqM && !MemReadyM) : !MemReadyM);
        if (sclr) begin
          eA = 2'b00; eB = 2'b00; eStall = 5'b00000; eFD = 1'b1; eFE = 1'b1;
        end else begin
          eA = fwdRule(Rs1E);
          eB = fwdRule(Rs2E);
          if (frz) begin
            eStall = 5'b11111; eFD = 1'b0; eFE = 1'b0;
          end else begin
            eStall = {load, load, 3'b000}; eFD = PCSrcE; eFE = load | PCSrcE;
          end
        end
        chk("model_stalls", {27'd0, StallF, StallD, StallE, StallM, StallW}, {27'd0, eStall});
        chk("model_flushD", {31'd0, FlushD}, {31'd0, eFD});
        chk("model_flushE", {31'd0, FlushE}, {31'd0, eFE});
        chk("model_fwdA", {30'd0, ForwardAE}, {30'd0, eA});
        chk("model_fwdB", {30'd0, ForwardBE}, {30'd0, eB});
        chk("model_busy", {31'd0, busy}, {31'd0, (timedOut || frozenCnt > 0)});
        chk("model_timeout", {31'd0, mem_timeout}, {31'd0, timedOut});
`ifdef HAZARD_PERF_EN
        chk("model_perf_stall", perf_stall_cycles, mStall);
        chk("model_perf_flush", perf_flush_count, mFlush);
        chk("model_perf_fwd", perf_fwd_count, mFwd);
        if (sclr) begin
          mStall = '0; mFlush = '0; mFwd = '0;
        end else begin
          if (eStall[4])               mStall = mStall + 1;
          if (PCSrcE && !frz)          mFlush = mFlush + 1;
          if (eA != 0 || eB != 0)      mFwd   = mFwd + 1;
        end
`endif
        if (sclr) begin
          frozenCnt = 0; timedOut = 1'b0;
        end else if (!timedOut) begin
          if (frz) begin
            frozenCnt++;
            if (frozenCnt == MaxWait + 1) timedOut = 1'b1;
          end else begin
            frozenCnt = 0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 2'b00; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic runTimeout(input string tag);
    step(); idle(); MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk({tag, "_frozen_stallF"}, {31'd0, StallF}, 32'd1);
      chk({tag, "_frozen_timeout"}, {31'd0, mem_timeout}, 32'd0);
      step();
    end
    #2;
    chk({tag, "_timeout_set"}, {31'd0, mem_timeout}, 32'd1);
    chk({tag, "_timeout_frozen"}, {31'd0, StallW}, 32'd1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    idle();
    sclr = 1;
    step(); #2;
    chk("rst_stallF", {31'd0, StallF}, 32'd0);
    chk("rst_flushD", {31'd0, FlushD}, 32'd1);
    chk("rst_flushE", {31'd0, FlushE}, 32'd1);
    step(); sclr = 0; #2;
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_timeout", {31'd0, mem_timeout}, 32'd0);
    chk("post_rst_flushD", {31'd0, FlushD}, 32'd0);

    // Forwarding priority and x0 exclusion
    step(); Rs1E = 5; Rs2E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; #2;
    chk("fwdA_M", {30'd0, ForwardAE}, 32'h2);
    chk("fwdB_M", {30'd0, ForwardBE}, 32'h2);
    step(); RdM = 0; #2;
    chk("fwdA_W", {30'd0, ForwardAE}, 32'h1);
    step(); RdW = 0; #2;
    chk("fwdA_none", {30'd0, ForwardAE}, 32'h0);
    step(); RdM = 5; RegWriteM = 0; RdW = 5; Rs2E = 9; #2;
    chk("fwdA_W_noRegWriteM", {30'd0, ForwardAE}, 32'h1);
    chk("fwdB_nomatch", {30'd0, ForwardBE}, 32'h0);

    // Load-use
    step(); idle(); ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; #2;
    chk("lw_stallF", {31'd0, StallF}, 32'd1);
    chk("lw_stallD", {31'd0, StallD}, 32'd1);
    chk("lw_flushE", {31'd0, FlushE}, 32'd1);
    chk("lw_flushD", {31'd0, FlushD}, 32'd0);
    chk("lw_stallE", {31'd0, StallE}, 32'd0);
    step(); ResultSrcE = 2'b00; #2;
    chk("lw_clear_stallF", {31'd0, StallF}, 32'd0);
    chk("lw_clear_flushE", {31'd0, FlushE}, 32'd0);
    step(); ResultSrcE = 2'b01; RdE = 0; Rs1D = 0; Rs2D = 0; #2;
    chk("lw_x0_stallF", {31'd0, StallF}, 32'd0);
    step(); RdE = 3; Rs1D = 3; PCSrcE = 1; #2;
    chk("lw_br_stallF", {31'd0, StallF}, 32'd1);
    chk("lw_br_flushD", {31'd0, FlushD}, 32'd1);

    // Branch flush for one cycle
    step(); idle(); PCSrcE = 1; #2;
    chk("br_flushD", {31'd0, FlushD}, 32'd1);
    chk("br_flushE", {31'd0, FlushE}, 32'd1);
    chk("br_stallF", {31'd0, StallF}, 32'd0);
    step(); PCSrcE = 0; #2;
    chk("br_done_flushD", {31'd0, FlushD}, 32'd0);

    // Memory wait of 3 cycles with a pending branch
    step(); MemReqM = 1; MemReadyM = 0; PCSrcE = 1; #2;
    chk("mw1_stallW", {31'd0, StallW}, 32'd1);
    chk("mw1_flushD", {31'd0, FlushD}, 32'd0);
    chk("mw1_busy", {31'd0, busy}, 32'd0);
    step(); #2;
    chk("mw2_stallF", {31'd0, StallF}, 32'd1);
    chk("mw2_busy", {31'd0, busy}, 32'd1);
    chk("mw2_flushE", {31'd0, FlushE}, 32'd0);
    step(); #2;
    chk("mw3_stallE", {31'd0, StallE}, 32'd1);
    step(); MemReadyM = 1; #2;
    chk("mw4_stallF", {31'd0, StallF}, 32'd0);
    chk("mw4_flushD", {31'd0, FlushD}, 32'd1);
    chk("mw4_flushE", {31'd0, FlushE}, 32'd1);
    step(); idle(); #2;
    chk("mw5_busy", {31'd0, busy}, 32'd0);

    // Timeout, sticky against MemReadyM, cleared by sclr
    runTimeout("to");
    step(); MemReadyM = 1; #2;
    chk("to_sticky_stall", {31'd0, StallF}, 32'd1);
    chk("to_sticky_flag", {31'd0, mem_timeout}, 32'd1);
    step(); idle(); sclr = 1; #2;
    chk("to_rst_flushD", {31'd0, FlushD}, 32'd1);
    chk("to_rst_stallF", {31'd0, StallF}, 32'd0);
    step(); sclr = 0; #2;
    chk("to_rst_timeout", {31'd0, mem_timeout}, 32'd0);
    chk("to_rst_busy", {31'd0, busy}, 32'd0);

    // sclr in the middle of a wait
    step(); MemReqM = 1; MemReadyM = 0;
    step(); step(); sclr = 1; #2;
    chk("midrst_flushE", {31'd0, FlushE}, 32'd1);
    chk("midrst_stallW", {31'd0, StallW}, 32'd0);
    step(); sclr = 0; idle(); #2;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
`ifdef HAZARD_PERF_EN
    chk("midrst_perf_stall", perf_stall_cycles, 32'd0);
    chk("midrst_perf_flush", perf_flush_count, 32'd0);
    chk("midrst_perf_fwd", perf_fwd_count, 32'd0);
`endif
    runTimeout("to2");

    step(); idle(); sclr = 1;
    step(); sclr = 0;
    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard/sequencing controller for the 5-stage RISC-V pipeline.
- Drives enable/clear of the IF/ID, ID/EX, EX/MEM and MEM/WB register banks, and the EX-stage operand-forwarding selects.
- Handles load-use stalls, taken-branch/jump flushes, and multi-cycle data-memory waits (whole-pipeline freeze) with a timeout watchdog.

Parameters:
- MAX_WAIT, 16: max MEM_WAIT counter value before declaring a memory timeout (range 1..255).

Ports:
- clk  in  1  clock, rising edge
- sclr  in  1  synchronous reset, active-high
- Rs1D, Rs2D  in  5 each  source regs in D
- Rs1E, Rs2E  in  5 each  source regs in E
- RdE, RdM, RdW  in  5 each  dest regs in E/M/W
- ResultSrcE  in  2  00 ALU, 01 load, 10 PC+4, 11 imm
- RegWriteM, RegWriteW  in  1 each  stage writes register file
- PCSrcE  in  1  branch/jump/jalr taken in E
- MemReqM  in  1  load or store in M
- MemReadyM  in  1  data memory completes this cycle
- StallF, StallD, StallE, StallM, StallW  out  1 each  hold PC / stage register (enable = ~Stall)
- FlushD, FlushE  out  1 each  sclr of IF/ID, ID/EX banks
- ForwardAE, ForwardBE  out  2 each  00 regfile, 10 M-stage result, 01 W-stage result
- mem_timeout  out  1  sticky memory-timeout error
- busy  out  1  high in MEM_WAIT or TIMEOUT

Behaviour:
- Clock and reset: one clock clk; sclr is synchronous and active-high.
- While sclr=1, outputs are forced:
  - All Stall* = 0; FlushD = FlushE = 1; ForwardAE/BE = 00.
  - On the next edge: state = RUN, wait_cnt = 0, mem_timeout = 0.
  - sclr in MEM_WAIT/TIMEOUT aborts the wait immediately.
- Forwarding (combinational, same cycle):
  - ForwardAE = 10 if RegWriteM & RdM!=0 & RdM==Rs1E.
  - Else ForwardAE = 01 if RegWriteW & RdW!=0 & RdW==Rs1E.
  - Else ForwardAE = 00.
  - M has priority over W. ForwardBE is identical using Rs2E.
  - Forwarding remains active during freeze.
- Load-use detection: lwStall = (ResultSrcE==01) & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- Normal (not frozen) outputs:
  - StallF = StallD = lwStall; StallE = StallM = StallW = 0.
  - FlushD = PCSrcE.
  - FlushE = lwStall | PCSrcE.
  - lwStall and PCSrcE together: stall and flush both asserted; the D bubble is cleared by FlushD.
- Freeze condition:
  - Frozen when (state==RUN & MemReqM & ~MemReadyM), or state==MEM_WAIT & ~MemReadyM, or state==TIMEOUT.
  - Frozen outputs: all five Stall* = 1, FlushD = FlushE = 0. Freeze overrides load-use and branch.
  - A PCSrcE held during freeze takes effect in the first unfrozen cycle; E is held, so PCSrcE is still valid then.
- FSM transitions (registered):
  - RUN: MemReqM & ~MemReadyM -> MEM_WAIT, wait_cnt <= 1. Otherwise stay. MemReqM & MemReadyM -> no stall.
  - MEM_WAIT, MemReadyM=1: -> RUN, wait_cnt <= 0. This cycle is unfrozen and the pipeline advances.
  - MEM_WAIT, ~MemReadyM & wait_cnt==MAX_WAIT: -> TIMEOUT, mem_timeout <= 1.
  - MEM_WAIT, otherwise: wait_cnt <= wait_cnt+1.
  - TIMEOUT: sticky until sclr; MemReadyM is ignored.
- Timing and counter width:
  - A request never ready gives exactly MAX_WAIT+1 frozen cycles before TIMEOUT.
  - wait_cnt is 8 bits and never wraps.
- busy = (state != RUN); registered-state derived.
- Register x0 is never a hazard source or target, per the Rd!=0 terms.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds three 32-bit outputs, all cleared by sclr and wrapping modulo 2^32:
  - perf_stall_cycles: counts cycles with StallF=1.
  - perf_flush_count: counts cycles with PCSrcE & ~frozen.
  - perf_fwd_count: counts cycles with ForwardAE!=00 or ForwardBE!=00.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. Same with RdM=0 -> ForwardAE=01. RdW=0 too -> 00.
- ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=1, FlushE=1, FlushD=0. Next cycle with ResultSrcE=00 -> all stalls 0.
- PCSrcE=1, no other hazard -> FlushD=FlushE=1 for exactly that cycle, Stall*=0.
- MemReqM=1, MemReadyM low 3 cycles then high -> all Stall*=1 for 3 cycles, busy=1 for cycles 2-3, 4th cycle unfrozen, state back to RUN. Concurrent PCSrcE=1 -> flush only in 4th cycle.
- MAX_WAIT=4, MemReqM=1, MemReadyM=0 forever -> 5 frozen cycles then mem_timeout=1, still frozen. MemReadyM=1 -> no change. sclr -> mem_timeout=0, state RUN.
- sclr asserted mid-MEM_WAIT (wait_cnt=2) -> FlushD=FlushE=1 and Stall*=0 during reset; after release, RUN with wait_cnt=0. With HAZARD_PERF_EN, all perf counters read 0.
